// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared types for the miner datapath
package miner_pkg;

  typedef enum logic [1:0] {
    NG_IDLE,
    NG_RUN,
    NG_DONE
  } nonce_gen_state_e;

endpackage

// File: rtl/nonce_range_gen.sv
// rtl/nonce_range_gen.sv - arithmetic nonce sequencer streaming start..end by step to the hash cores
module nonce_range_gen
  import miner_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_start,
  input  logic [WIDTH-1:0] ld_end,
  input  logic [WIDTH-1:0] ld_step,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] nonce_o,
  output logic             nonce_valid,
  input  logic             nonce_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] issued_o
);

  nonce_gen_state_e state_q, state_d;
  logic [WIDTH-1:0] nonce_q, nonce_d;
  logic [WIDTH-1:0] end_q, end_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             pend_q, pend_d;
  logic [WIDTH:0]   nxt;
  logic             xfer;

  always_comb begin
    state_d  = state_q;
    nonce_d  = nonce_q;
    end_d    = end_q;
    step_d   = step_q;
    issued_d = issued_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    pend_d   = pend_q;
    // One extra bit so the overshoot past an all-ones end is still visible
    nxt      = {1'b0, nonce_q} + {1'b0, step_q};
    xfer     = valid_q & nonce_ready;

    if (ld) begin
      end_d    = ld_end;
      step_d   = (ld_step == '0) ? WIDTH'(1) : ld_step;
      nonce_d  = ld_start;
      issued_d = '0;
      valid_d  = 1'b0;
      pend_d   = 1'b0;
      if (ld_start > ld_end) begin
        state_d = NG_DONE;
        pend_d  = 1'b1;
      end else begin
        state_d = NG_RUN;
      end
    end else if (abort) begin
      state_d = NG_IDLE;
      valid_d = 1'b0;
      pend_d  = 1'b0;
      if (xfer) issued_d = issued_q + CNT_W'(1);
    end else begin
      case (state_q)
        NG_RUN: begin
          if (xfer) begin
            issued_d = issued_q + CNT_W'(1);
            if (nxt > {1'b0, end_q}) begin
              state_d = NG_DONE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              nonce_d = nxt[WIDTH-1:0];
              valid_d = en;
            end
          end else if (en) begin
            valid_d = 1'b1;
          end
        end
        // An empty range announces itself one cycle after entering DONE
        NG_DONE: begin
          done_d = pend_q;
          pend_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= NG_IDLE;
      nonce_q  <= '0;
      end_q    <= '0;
      step_q   <= '0;
      issued_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      nonce_q  <= nonce_d;
      end_q    <= end_d;
      step_q   <= step_d;
      issued_q <= issued_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      pend_q   <= pend_d;
    end
  end

  assign nonce_o     = nonce_q;
  assign nonce_valid = valid_q;
  assign busy        = (state_q == NG_RUN);
  assign done        = done_q;
  assign issued_o    = issued_q;

endmodule

// File: tb/tb_nonce_range_gen.sv
// tb/tb_nonce_range_gen.sv - scoreboard bench for nonce_range_gen
module tb_nonce_range_gen;

  localparam int W  = 32;
  localparam int CW = W + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld = 1'b0;
  logic [W-1:0]  ld_start = '0;
  logic [W-1:0]  ld_end = '0;
  logic [W-1:0]  ld_step = '0;
  logic          en = 1'b0;
  logic          abort = 1'b0;
  logic          nonce_ready = 1'b0;
  logic [W-1:0]  nonce_o;
  logic          nonce_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] issued_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int n_done, done_at, last_x, both_bad, valid_seen;

  nonce_range_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ld(ld), .ld_start(ld_start), .ld_end(ld_end),
    .ld_step(ld_step), .en(en), .abort(abort), .nonce_o(nonce_o),
    .nonce_valid(nonce_valid), .nonce_ready(nonce_ready), .busy(busy),
    .done(done), .issued_o(issued_o)
  );

  always #5 clk = ~clk;

  // Reference sequence, computed wide so it cannot wrap
  function automatic void push_range(input logic [W-1:0] s, input logic [W-1:0] e,
                                     input logic [W-1:0] st);
    logic [W:0] cur, stp;
    int n;
    stp = (st == '0) ? (W+1)'(1) : {1'b0, st};
    cur = {1'b0, s};
    n = 0;
    while (cur <= {1'b0, e} && n < 64) begin
      exp_q.push_back(cur[W-1:0]);
      cur = cur + stp;
      n++;
    end
  endfunction

  task automatic do_ld(input logic [W-1:0] s, input logic [W-1:0] e, input logic [W-1:0] st);
    ld = 1'b1; ld_start = s; ld_end = e; ld_step = st;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  // Records transfers and done pulses; comparisons are made by the callers
  task automatic collect(input int cycles);
    obs_q.delete();
    n_done = 0; done_at = -1; last_x = -1; both_bad = 0; valid_seen = 0;
    for (int c = 0; c < cycles; c++) begin
      if (nonce_valid) valid_seen++;
      if (nonce_valid && nonce_ready) begin
        obs_q.push_back(nonce_o);
        last_x = c;
      end
      if (done) begin
        n_done++;
        done_at = c;
      end
      if (done && nonce_valid) both_bad++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld = 1'b1; ld_start = 32'd5; ld_end = 32'd9; ld_step = 32'd1; en = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    ld = 1'b0;
    total_cnt++; if (nonce_o !== '0) $display("FAIL reset_nonce: got %0h want 0", nonce_o); else pass_cnt++;
    total_cnt++; if (nonce_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", nonce_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (issued_o !== '0) $display("FAIL reset_issued: got %0d want 0", issued_o); else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [W-1:0] o, x;
    en = 1'b1; nonce_ready = 1'b1;
    push_range(32'd10, 32'd20, 32'd5);
    do_ld(32'd10, 32'd20, 32'd5);
    collect(12);
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      total_cnt++; if (o !== x) $display("FAIL basic_nonce: got %0d want %0d", o, x); else pass_cnt++;
    end
    exp_q.delete();
    total_cnt++; if (n_done != 1) $display("FAIL basic_done_pulses: got %0d want 1", n_done); else pass_cnt++;
    total_cnt++; if (done_at != last_x + 1) $display("FAIL basic_done_time: got %0d want %0d", done_at, last_x + 1); else pass_cnt++;
    total_cnt++; if (both_bad != 0) $display("FAIL basic_done_with_valid: got %0d want 0", both_bad); else pass_cnt++;
    total_cnt++; if (issued_o !== CW'(3)) $display("FAIL basic_issued: got %0d want 3", issued_o); else pass_cnt++;
    total_cnt++; if (nonce_o !== 32'd20) $display("FAIL basic_hold_nonce: got %0d want 20", nonce_o); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_done: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_top_of_range();
    logic [W-1:0] o, x;
    en = 1'b1; nonce_ready = 1'b1;
    push_range(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1);
    do_ld(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1);
    collect(10);
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL top_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      total_cnt++; if (o !== x) $display("FAIL top_nonce: got %0h want %0h", o, x); else pass_cnt++;
    end
    exp_q.delete();
    total_cnt++; if (n_done != 1) $display("FAIL top_done_pulses: got %0d want 1", n_done); else pass_cnt++;
    total_cnt++; if (issued_o !== CW'(2)) $display("FAIL top_issued: got %0d want 2", issued_o); else pass_cnt++;
    total_cnt++; if (nonce_o !== 32'hFFFF_FFFF) $display("FAIL top_hold_nonce: got %0h want ffffffff", nonce_o); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] o, x;
    en = 1'b1; nonce_ready = 1'b0;
    push_range(32'd50, 32'd80, 32'd10);
    do_ld(32'd50, 32'd80, 32'd10);
    @(posedge clk); #1;
    total_cnt++; if (nonce_valid !== 1'b1) $display("FAIL stall_valid_rise: got %b want 1", nonce_valid); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      en = i[0];
      @(posedge clk); #1;
      total_cnt++; if (nonce_valid !== 1'b1) $display("FAIL stall_valid_hold: got %b want 1", nonce_valid); else pass_cnt++;
      total_cnt++; if (nonce_o !== 32'd50) $display("FAIL stall_nonce_hold: got %0d want 50", nonce_o); else pass_cnt++;
    end
    en = 1'b1; nonce_ready = 1'b1;
    collect(10);
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL stall_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      total_cnt++; if (o !== x) $display("FAIL stall_nonce: got %0d want %0d", o, x); else pass_cnt++;
    end
    exp_q.delete();
    total_cnt++; if (issued_o !== CW'(4)) $display("FAIL stall_issued: got %0d want 4", issued_o); else pass_cnt++;
  endtask

  task automatic test_empty_and_step0();
    logic [W-1:0] o, x;
    en = 1'b1; nonce_ready = 1'b1;
    do_ld(32'd7, 32'd3, 32'd1);
    collect(5);
    total_cnt++; if (valid_seen != 0) $display("FAIL empty_valid: got %0d want 0", valid_seen); else pass_cnt++;
    total_cnt++; if (n_done != 1) $display("FAIL empty_done_pulses: got %0d want 1", n_done); else pass_cnt++;
    total_cnt++; if (done_at != 1) $display("FAIL empty_done_time: got %0d want 1", done_at); else pass_cnt++;
    total_cnt++; if (issued_o !== '0) $display("FAIL empty_issued: got %0d want 0", issued_o); else pass_cnt++;
    push_range(32'd0, 32'd2, 32'd0);
    do_ld(32'd0, 32'd2, 32'd0);
    collect(10);
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL step0_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      total_cnt++; if (o !== x) $display("FAIL step0_nonce: got %0d want %0d", o, x); else pass_cnt++;
    end
    exp_q.delete();
  endtask

  task automatic test_abort();
    logic [W-1:0] o, x;
    // abort coinciding with a transfer still counts that transfer
    en = 1'b1; nonce_ready = 1'b1;
    do_ld(32'd0, 32'd9, 32'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    total_cnt++; if (issued_o !== CW'(1)) $display("FAIL abort_xfer_issued: got %0d want 1", issued_o); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_xfer_busy: got %b want 0", busy); else pass_cnt++;

    nonce_ready = 1'b0;
    do_ld(32'd200, 32'd300, 32'd1);
    @(posedge clk); #1;
    total_cnt++; if (nonce_valid !== 1'b1) $display("FAIL abort_pre_valid: got %b want 1", nonce_valid); else pass_cnt++;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    total_cnt++; if (nonce_valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", nonce_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (issued_o !== '0) $display("FAIL abort_issued: got %0d want 0", issued_o); else pass_cnt++;
    collect(4);
    total_cnt++; if (n_done != 0) $display("FAIL abort_done: got %0d want 0", n_done); else pass_cnt++;
    total_cnt++; if (valid_seen != 0) $display("FAIL abort_idle_valid: got %0d want 0", valid_seen); else pass_cnt++;
    nonce_ready = 1'b1;
    push_range(32'd100, 32'd102, 32'd1);
    do_ld(32'd100, 32'd102, 32'd1);
    collect(10);
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL abort_reload_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      total_cnt++; if (o !== x) $display("FAIL abort_reload_nonce: got %0d want %0d", o, x); else pass_cnt++;
    end
    exp_q.delete();
  endtask

  task automatic test_reset_and_reload();
    logic [W-1:0] o, x;
    en = 1'b1; nonce_ready = 1'b1;
    do_ld(32'd1000, 32'd2000, 32'd1);
    collect(3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if ({nonce_o, nonce_valid, busy, done} !== '0) $display("FAIL midrun_reset_outputs: got %0h/%b/%b/%b want 0", nonce_o, nonce_valid, busy, done); else pass_cnt++;
    total_cnt++; if (issued_o !== '0) $display("FAIL midrun_reset_issued: got %0d want 0", issued_o); else pass_cnt++;
    rst_n = 1'b1;
    nonce_ready = 1'b0;
    do_ld(32'd500, 32'd600, 32'd1);
    @(posedge clk); #1;
    total_cnt++; if (nonce_valid !== 1'b1 || nonce_o !== 32'd500) $display("FAIL reload_old_first: got %b/%0d want 1/500", nonce_valid, nonce_o); else pass_cnt++;
    do_ld(32'd40, 32'd42, 32'd1);
    total_cnt++; if (nonce_valid !== 1'b0) $display("FAIL reload_discard: got %b want 0", nonce_valid); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (nonce_valid !== 1'b1 || nonce_o !== 32'd40) $display("FAIL reload_new_first: got %b/%0d want 1/40", nonce_valid, nonce_o); else pass_cnt++;
    nonce_ready = 1'b1;
    push_range(32'd40, 32'd42, 32'd1);
    collect(8);
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL reload_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      total_cnt++; if (o !== x) $display("FAIL reload_nonce: got %0d want %0d", o, x); else pass_cnt++;
    end
    exp_q.delete();
    total_cnt++; if (issued_o !== CW'(3)) $display("FAIL reload_issued: got %0d want 3", issued_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_top_of_range();
    test_backpressure();
    test_empty_and_step0();
    test_abort();
    test_reset_and_reload();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
